// File: rtl/mem_responder_if.sv
// ---------------------------------------------------------------------------
// mem_responder_if
//   CPU-side memory bus seen by mem_responder.
//
//   mem_addr  16  CPU address (instruction fetch or load/store)
//   mem_din   16  CPU store data
//   mem_WE     1  CPU write enable
//   mem_dout  16  read data returned to the CPU, one cycle after the address
//
//   master : the CPU (drives address/data/write enable, receives read data)
//   slave  : the responder (receives address/data/write enable, drives read data)
// ---------------------------------------------------------------------------
interface mem_responder_if;
    logic [15:0] mem_addr;
    logic [15:0] mem_din;
    logic        mem_WE;
    logic [15:0] mem_dout;

    modport master (
        output mem_addr,
        output mem_din,
        output mem_WE,
        input  mem_dout
    );

    modport slave (
        input  mem_addr,
        input  mem_din,
        input  mem_WE,
        output mem_dout
    );
endinterface

// File: rtl/mem_responder.sv
// ---------------------------------------------------------------------------
// mem_responder
//   Address decoder and MMIO block sitting between a 16-bit CPU and a
//   single-port BRAM. Addresses 0x0000-0xFEFF go to the BRAM; page 0xFFxx
//   holds the peripherals:
//     0xFF00  keyboard status  {10'b0, count[3:0], overflow, nonempty}
//             write with din[1]=1 clears the sticky overflow flag
//     0xFF01  keyboard data    {8'h00, scancode}, popped once per read burst
//     0xFF02  LED register     read/write
//     0xFF03  free-running timer (only with MEM_RESP_TIMER_EN)
//     others  reserved: read 0x0000, writes ignored
//   All reads have one cycle of latency so MMIO lines up with the BRAM.
//
// Ports
//   clk        system clock, all state on the rising edge
//   rst        asynchronous, active-high reset
//   bus        CPU bus (mem_responder_if.slave)
//   bram_addr  BRAM port A address   (combinational copy of mem_addr)
//   bram_din   BRAM port A write data (combinational copy of mem_din)
//   bram_we    BRAM write enable, only asserted for BRAM-region writes
//   bram_dout  BRAM read data, one-cycle latency
//   kb_code    PS/2 scancode
//   kb_valid   one-cycle strobe qualifying kb_code
//   led        LED register contents
//
// Build option
//   MEM_RESP_TIMER_EN  when defined, 0xFF03 is a 16-bit counter that
//                      increments every cycle and can be loaded by a write;
//                      when undefined, 0xFF03 behaves as a reserved address.
// ---------------------------------------------------------------------------
module mem_responder (
    input  logic            clk,
    input  logic            rst,
    mem_responder_if.slave  bus,
    output logic [15:0]     bram_addr,
    output logic [15:0]     bram_din,
    output logic            bram_we,
    input  logic [15:0]     bram_dout,
    input  logic [7:0]      kb_code,
    input  logic            kb_valid,
    output logic [15:0]     led
);

    localparam logic [7:0] MMIO_PAGE   = 8'hFF;
    localparam logic [7:0] OFS_KB_STAT = 8'h00;
    localparam logic [7:0] OFS_KB_DATA = 8'h01;
    localparam logic [7:0] OFS_LED     = 8'h02;
    localparam logic [7:0] OFS_TIMER   = 8'h03;
    localparam logic [3:0] FIFO_DEPTH  = 4'd8;

    // -----------------------------------------------------------------------
    // Address decode
    // -----------------------------------------------------------------------
    logic       is_mmio;
    logic [7:0] mmio_ofs;
    logic       stat_wr;
    logic       led_wr;
    logic       kb_rd;

    assign is_mmio  = (bus.mem_addr[15:8] == MMIO_PAGE);
    assign mmio_ofs = bus.mem_addr[7:0];

    assign stat_wr = is_mmio && (mmio_ofs == OFS_KB_STAT) && bus.mem_WE;
    assign led_wr  = is_mmio && (mmio_ofs == OFS_LED)     && bus.mem_WE;
    assign kb_rd   = is_mmio && (mmio_ofs == OFS_KB_DATA) && !bus.mem_WE;

    // BRAM port is a straight pass-through; only the write enable is gated
    // so MMIO stores never corrupt memory. Kept combinational so it is
    // also low during reset whenever the CPU is not writing.
    assign bram_addr = bus.mem_addr;
    assign bram_din  = bus.mem_din;
    assign bram_we   = bus.mem_WE && !is_mmio;

    // -----------------------------------------------------------------------
    // Keyboard FIFO (8 x 8)
    // -----------------------------------------------------------------------
    logic [7:0] fifo_mem [8];
    logic [2:0] wr_ptr;
    logic [2:0] rd_ptr;
    logic [3:0] count;
    logic       overflow;
    logic       kb_hold_q;

    logic fifo_empty;
    logic fifo_full;
    logic kb_entry;
    logic pop;
    logic push;
    logic ovf_event;
    logic ovf_clr;

    assign fifo_empty = (count == 4'd0);
    assign fifo_full  = (count == FIFO_DEPTH);

    // A data read pops only on its first cycle; holding the address keeps
    // the captured byte on mem_dout without draining further entries.
    assign kb_entry = kb_rd && !kb_hold_q;
    assign pop      = kb_entry && !fifo_empty;

    // When full, a push is still accepted if a pop frees a slot in the
    // same cycle; otherwise it is dropped and flagged.
    assign push      = kb_valid && (!fifo_full || pop);
    assign ovf_event = kb_valid && fifo_full && !pop;
    assign ovf_clr   = stat_wr && bus.mem_din[1];

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= kb_code;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            kb_hold_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 3'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 3'd1;
            end
            case ({push, pop})
                2'b10:   count <= count + 4'd1;
                2'b01:   count <= count - 4'd1;
                default: count <= count;
            endcase
            // A drop in the same cycle as a clear leaves the flag set.
            overflow  <= ovf_event || (overflow && !ovf_clr);
            kb_hold_q <= kb_rd;
        end
    end

    // -----------------------------------------------------------------------
    // LED register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led <= '0;
        end else if (led_wr) begin
            led <= bus.mem_din;
        end
    end

    // -----------------------------------------------------------------------
    // Timer
    // -----------------------------------------------------------------------
    logic [15:0] timer_val;

`ifdef MEM_RESP_TIMER_EN
    logic        timer_wr;
    logic [15:0] timer_q;

    assign timer_wr = is_mmio && (mmio_ofs == OFS_TIMER) && bus.mem_WE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer_q <= '0;
        end else if (timer_wr) begin
            timer_q <= bus.mem_din;
        end else begin
            timer_q <= timer_q + 16'd1;
        end
    end

    assign timer_val = timer_q;
`else
    assign timer_val = 16'h0000;
`endif

    // -----------------------------------------------------------------------
    // Read path
    // -----------------------------------------------------------------------
    logic [15:0] rd_val;
    logic [15:0] rdata_q;
    logic        region_bram_q;

    always_comb begin
        rd_val = 16'h0000;
        if (is_mmio) begin
            case (mmio_ofs)
                OFS_KB_STAT: rd_val = {10'b0, count, overflow, !fifo_empty};
                OFS_KB_DATA: rd_val = pop ? {8'h00, fifo_mem[rd_ptr]} : 16'h0000;
                OFS_LED:     rd_val = led;
                OFS_TIMER:   rd_val = timer_val;
                default:     rd_val = 16'h0000;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            region_bram_q <= 1'b0;
            rdata_q       <= '0;
        end else begin
            region_bram_q <= !is_mmio;
            if (!(kb_rd && kb_hold_q)) begin
                rdata_q <= rd_val;
            end
        end
    end

    assign bus.mem_dout = region_bram_q ? bram_dout : rdata_q;

endmodule
